// File: rtl/pipe_front_regs_pkg.sv
// Shared CPU front-end constants and the packed ID/EX control bundle.
package pipe_front_regs_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 4;
  localparam int ALU_OP_W = 4;

  localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;
  localparam logic [DATA_W-1:0] RESET_PC  = 16'h0000;

  typedef struct packed {
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                branch;
    logic [ALU_OP_W-1:0] alu_op;
  } idex_ctrl_t;

endpackage

// File: rtl/pipe_front_regs_if.sv
// Bundle between fetch/decode/hazard logic and the front-end pipeline registers.
interface pipe_front_regs_if;
  import pipe_front_regs_pkg::*;

  logic [DATA_W-1:0]   imem_instr;
  logic                pc_write;
  logic                ifid_write;
  logic                idex_flush;
  logic                ex_redirect;
  logic [DATA_W-1:0]   ex_target;
  logic [REG_AW-1:0]   id_rs1;
  logic [REG_AW-1:0]   id_rs2;
  logic [REG_AW-1:0]   id_rd;
  logic [DATA_W-1:0]   id_imm;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic                id_mem_read;
  logic                id_mem_write;
  logic                id_reg_write;
  logic                id_branch;

  logic [DATA_W-1:0]   pc;
  logic [DATA_W-1:0]   ifid_instr;
  logic [DATA_W-1:0]   ifid_pc;
  logic                ifid_valid;
  logic [REG_AW-1:0]   ifid_rs1;
  logic [REG_AW-1:0]   ifid_rs2;
  logic [REG_AW-1:0]   idex_rs1;
  logic [REG_AW-1:0]   idex_rs2;
  logic [REG_AW-1:0]   idex_rd;
  logic [DATA_W-1:0]   idex_imm;
  logic [DATA_W-1:0]   idex_pc;
  logic [ALU_OP_W-1:0] idex_alu_op;
  logic                idex_mem_read;
  logic                idex_mem_write;
  logic                idex_reg_write;
  logic                idex_branch;
  logic                idex_valid;
  logic [15:0]         stall_cnt;
  logic [15:0]         flush_cnt;

  modport master (
    output imem_instr, pc_write, ifid_write, idex_flush, ex_redirect, ex_target,
           id_rs1, id_rs2, id_rd, id_imm, id_alu_op,
           id_mem_read, id_mem_write, id_reg_write, id_branch,
    input  pc, ifid_instr, ifid_pc, ifid_valid, ifid_rs1, ifid_rs2,
           idex_rs1, idex_rs2, idex_rd, idex_imm, idex_pc, idex_alu_op,
           idex_mem_read, idex_mem_write, idex_reg_write, idex_branch, idex_valid,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  imem_instr, pc_write, ifid_write, idex_flush, ex_redirect, ex_target,
           id_rs1, id_rs2, id_rd, id_imm, id_alu_op,
           id_mem_read, id_mem_write, id_reg_write, id_branch,
    output pc, ifid_instr, ifid_pc, ifid_valid, ifid_rs1, ifid_rs2,
           idex_rs1, idex_rs2, idex_rd, idex_imm, idex_pc, idex_alu_op,
           idex_mem_read, idex_mem_write, idex_reg_write, idex_branch, idex_valid,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_front_regs_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] count
);

  // Count enabled events, holding once the maximum is reached.
  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= 16'h0000;
    else if (en && (count != 16'hFFFF))
      count <= count + 16'h0001;
  end

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers with stall, flush and redirect handling.
module pipe_front_regs
  import pipe_front_regs_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC_P = RESET_PC,
  parameter logic [DATA_W-1:0] PC_INC     = 16'd1
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_front_regs_if.slave   bus
);

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] ifid_instr_q;
  logic [DATA_W-1:0] ifid_pc_q;
  logic              ifid_valid_q;
  logic [REG_AW-1:0] idex_rs1_q;
  logic [REG_AW-1:0] idex_rs2_q;
  logic [REG_AW-1:0] idex_rd_q;
  logic [DATA_W-1:0] idex_imm_q;
  logic [DATA_W-1:0] idex_pc_q;
  logic              idex_valid_q;
  idex_ctrl_t        idex_ctrl_q;
  idex_ctrl_t        id_ctrl;
  logic              idex_bubble;
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  assign idex_bubble = bus.ex_redirect | bus.idex_flush;

  // Fetch PC: a resolved redirect beats a normal advance.
  always_ff @(posedge clk) begin
    if (!rst_n)
      pc_q <= RESET_PC_P;
    else if (bus.ex_redirect)
      pc_q <= bus.ex_target;
    else if (bus.pc_write)
      pc_q <= pc_q + PC_INC;
  end

  // IF/ID: a redirect squashes the fetched instruction even while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.ex_redirect) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else if (bus.ifid_write) begin
      ifid_instr_q <= bus.imem_instr;
      ifid_pc_q    <= pc_q;
      ifid_valid_q <= 1'b1;
    end
  end

  // Decoded controls are only meaningful for a real instruction in IF/ID.
  always_comb begin
    id_ctrl = '0;
    if (ifid_valid_q) begin
      id_ctrl.mem_read  = bus.id_mem_read;
      id_ctrl.mem_write = bus.id_mem_write;
      id_ctrl.reg_write = bus.id_reg_write;
      id_ctrl.branch    = bus.id_branch;
      id_ctrl.alu_op    = bus.id_alu_op;
    end
  end

  // ID/EX: load a bubble on redirect or hazard flush, otherwise the decode.
  always_ff @(posedge clk) begin
    if (!rst_n || idex_bubble) begin
      idex_rs1_q   <= '0;
      idex_rs2_q   <= '0;
      idex_rd_q    <= '0;
      idex_imm_q   <= '0;
      idex_pc_q    <= '0;
      idex_valid_q <= 1'b0;
      idex_ctrl_q  <= '0;
    end else begin
      idex_rs1_q   <= bus.id_rs1;
      idex_rs2_q   <= bus.id_rs2;
      idex_rd_q    <= bus.id_rd;
      idex_imm_q   <= bus.id_imm;
      idex_pc_q    <= ifid_pc_q;
      idex_valid_q <= ifid_valid_q;
      idex_ctrl_q  <= id_ctrl;
    end
  end

  // A stall discarded by a coincident redirect is not counted as a stall.
  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.idex_flush & ~bus.ex_redirect),
    .count (stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.ex_redirect),
    .count (flush_cnt)
  );

  assign bus.pc             = pc_q;
  assign bus.ifid_instr     = ifid_instr_q;
  assign bus.ifid_pc        = ifid_pc_q;
  assign bus.ifid_valid     = ifid_valid_q;
  assign bus.ifid_rs1       = ifid_valid_q ? bus.id_rs1 : '0;
  assign bus.ifid_rs2       = ifid_valid_q ? bus.id_rs2 : '0;
  assign bus.idex_rs1       = idex_rs1_q;
  assign bus.idex_rs2       = idex_rs2_q;
  assign bus.idex_rd        = idex_rd_q;
  assign bus.idex_imm       = idex_imm_q;
  assign bus.idex_pc        = idex_pc_q;
  assign bus.idex_alu_op    = idex_ctrl_q.alu_op;
  assign bus.idex_mem_read  = idex_ctrl_q.mem_read;
  assign bus.idex_mem_write = idex_ctrl_q.mem_write;
  assign bus.idex_reg_write = idex_ctrl_q.reg_write;
  assign bus.idex_branch    = idex_ctrl_q.branch;
  assign bus.idex_valid     = idex_valid_q;
  assign bus.stall_cnt      = stall_cnt;
  assign bus.flush_cnt      = flush_cnt;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed and random checks of the front-end pipeline registers against a stage model.
module tb_pipe_front_regs;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pipe_front_regs_if bus_if ();

  pipe_front_regs dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
  } ifid_t;

  typedef struct {
    logic [3:0]  rs1, rs2, rd, alu_op;
    logic [15:0] imm, pc;
    logic        mem_read, mem_write, reg_write, branch, valid;
  } idex_t;

  logic [15:0] m_pc, m_stall, m_flush;
  ifid_t       m_ifid;
  idex_t       m_idex;
  idex_t       bubble_idex;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pc",         bus_if.pc,             m_pc);
    chk("ifid_instr", bus_if.ifid_instr,     m_ifid.instr);
    chk("ifid_pc",    bus_if.ifid_pc,        m_ifid.pc);
    chk("ifid_valid", bus_if.ifid_valid,     m_ifid.valid);
    chk("ifid_rs1",   bus_if.ifid_rs1,       m_ifid.valid ? bus_if.id_rs1 : 4'd0);
    chk("ifid_rs2",   bus_if.ifid_rs2,       m_ifid.valid ? bus_if.id_rs2 : 4'd0);
    chk("idex_rs1",   bus_if.idex_rs1,       m_idex.rs1);
    chk("idex_rs2",   bus_if.idex_rs2,       m_idex.rs2);
    chk("idex_rd",    bus_if.idex_rd,        m_idex.rd);
    chk("idex_imm",   bus_if.idex_imm,       m_idex.imm);
    chk("idex_pc",    bus_if.idex_pc,        m_idex.pc);
    chk("idex_alu",   bus_if.idex_alu_op,    m_idex.alu_op);
    chk("idex_mrd",   bus_if.idex_mem_read,  m_idex.mem_read);
    chk("idex_mwr",   bus_if.idex_mem_write, m_idex.mem_write);
    chk("idex_rwr",   bus_if.idex_reg_write, m_idex.reg_write);
    chk("idex_br",    bus_if.idex_branch,    m_idex.branch);
    chk("idex_valid", bus_if.idex_valid,     m_idex.valid);
    chk("stall_cnt",  bus_if.stall_cnt,      m_stall);
    chk("flush_cnt",  bus_if.flush_cnt,      m_flush);
  endtask

  // One clock: predict every stage from the rules, then compare after the edge.
  task automatic step(input bit full = 1'b1);
    logic [15:0] n_pc, n_stall, n_flush;
    ifid_t       n_ifid;
    idex_t       n_idex;
    bit          real_instr;
    if (!rst_n) begin
      n_pc    = 16'h0000;
      n_ifid  = '{16'h0000, 16'h0000, 1'b0};
      n_idex  = bubble_idex;
      n_stall = 16'h0000;
      n_flush = 16'h0000;
    end else begin
      n_pc    = bus_if.ex_redirect ? bus_if.ex_target :
                bus_if.pc_write    ? 16'((32'(m_pc) + 1) % 65536) : m_pc;
      n_ifid  = bus_if.ex_redirect ? '{16'h0000, 16'h0000, 1'b0} :
                bus_if.ifid_write  ? '{bus_if.imem_instr, m_pc, 1'b1} : m_ifid;
      if (bus_if.ex_redirect || bus_if.idex_flush) n_idex = bubble_idex;
      else begin
        real_instr       = m_ifid.valid;
        n_idex.rs1       = bus_if.id_rs1;
        n_idex.rs2       = bus_if.id_rs2;
        n_idex.rd        = bus_if.id_rd;
        n_idex.imm       = bus_if.id_imm;
        n_idex.pc        = m_ifid.pc;
        n_idex.valid     = m_ifid.valid;
        n_idex.alu_op    = real_instr ? bus_if.id_alu_op : 4'd0;
        n_idex.mem_read  = real_instr && bus_if.id_mem_read;
        n_idex.mem_write = real_instr && bus_if.id_mem_write;
        n_idex.reg_write = real_instr && bus_if.id_reg_write;
        n_idex.branch    = real_instr && bus_if.id_branch;
      end
      n_stall = (bus_if.idex_flush && !bus_if.ex_redirect && m_stall < 16'hFFFF) ? m_stall + 16'd1 : m_stall;
      n_flush = (bus_if.ex_redirect && m_flush < 16'hFFFF) ? m_flush + 16'd1 : m_flush;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ifid = n_ifid; m_idex = n_idex; m_stall = n_stall; m_flush = n_flush;
    if (full) check_all();
  endtask

  task automatic drive(input bit pw, input bit iw, input bit fl, input bit rd, input logic [15:0] tgt);
    bus_if.pc_write    = pw;
    bus_if.ifid_write  = iw;
    bus_if.idex_flush  = fl;
    bus_if.ex_redirect = rd;
    bus_if.ex_target   = tgt;
  endtask

  task automatic decode(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd, input bit mrd);
    bus_if.id_rs1       = rs1;
    bus_if.id_rs2       = rs2;
    bus_if.id_rd        = rd;
    bus_if.id_imm       = 16'(rd) * 16'd3 + 16'h0100;
    bus_if.id_alu_op    = 4'(rs1 + rs2);
    bus_if.id_mem_read  = mrd;
    bus_if.id_mem_write = 1'b0;
    bus_if.id_reg_write = 1'b1;
    bus_if.id_branch    = 1'b0;
  endtask

  initial begin
    logic [15:0] held_pc, held_instr, held_ifid_pc, saved_stall;
    bubble_idex = '{rs1: 4'd0, rs2: 4'd0, rd: 4'd0, alu_op: 4'd0, imm: 16'd0, pc: 16'd0,
                    mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0, branch: 1'b0, valid: 1'b0};
    m_pc = 16'hxxxx; m_ifid = '{16'hxxxx, 16'hxxxx, 1'bx}; m_idex = bubble_idex;
    m_stall = 16'hxxxx; m_flush = 16'hxxxx;

    // Reset held two cycles with a live instruction on the bus.
    rst_n = 1'b0;
    bus_if.imem_instr = 16'h1234;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    decode(4'd1, 4'd2, 4'd5, 1'b0);
    step(); step();
    chk("rst_pc", bus_if.pc, 16'h0000);
    chk("rst_ifid_valid", bus_if.ifid_valid, 1'b0);
    chk("rst_idex_valid", bus_if.idex_valid, 1'b0);
    chk("rst_cnts", {bus_if.stall_cnt, bus_if.flush_cnt}, 32'h0);

    // Release: A=1234 fetched at pc 0, then B, C straight-line.
    rst_n = 1'b1;
    step();
    chk("rel_pc", bus_if.pc, 16'h0001);
    chk("rel_ifid_instr", bus_if.ifid_instr, 16'h1234);
    chk("rel_ifid_pc", bus_if.ifid_pc, 16'h0000);
    bus_if.imem_instr = 16'hB0B0;
    step();
    chk("A_idex_pc", bus_if.idex_pc, 16'h0000);
    chk("A_idex_valid", bus_if.idex_valid, 1'b1);
    chk("line_pc", bus_if.pc, 16'h0002);
    bus_if.imem_instr = 16'hC0C0;
    step();
    chk("line_pc3", bus_if.pc, 16'h0003);

    // Load with rd=3 enters ID/EX, then the dependent instruction stalls.
    bus_if.imem_instr = 16'hD0D0;
    decode(4'd0, 4'd0, 4'd3, 1'b1);
    step();
    chk("load_in_idex", {bus_if.idex_mem_read, bus_if.idex_rd}, {1'b1, 4'd3});
    held_pc = m_pc; held_instr = m_ifid.instr; held_ifid_pc = m_ifid.pc;
    decode(4'd3, 4'd4, 4'd6, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step();
    chk("stall_pc_hold", bus_if.pc, held_pc);
    chk("stall_ifid_hold", bus_if.ifid_instr, held_instr);
    chk("stall_bubble", {bus_if.idex_valid, bus_if.idex_mem_read}, 2'b00);
    chk("stall_cnt_1", bus_if.stall_cnt, 16'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    chk("held_enters_idex", {bus_if.idex_valid, bus_if.idex_pc, bus_if.idex_rs1}, {1'b1, held_ifid_pc, 4'd3});

    // Redirect alone, then redirect coincident with a stall.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040);
    step();
    chk("redir_pc", bus_if.pc, 16'h0040);
    chk("redir_bubbles", {bus_if.ifid_valid, bus_if.idex_valid}, 2'b00);
    chk("redir_flush_cnt", bus_if.flush_cnt, 16'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step(); step();
    saved_stall = m_stall;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0040);
    step();
    chk("redir_stall_pc", bus_if.pc, 16'h0040);
    chk("redir_stall_bubbles", {bus_if.ifid_valid, bus_if.idex_valid}, 2'b00);
    chk("redir_stall_cnt", bus_if.stall_cnt, saved_stall);

    // PC wraps from FFFF to 0000.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    chk("pc_wrap", bus_if.pc, 16'h0000);

    // Randomized traffic with independent enables and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      bus_if.imem_instr = 16'($urandom);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0, 16'($urandom));
      bus_if.id_rs1       = 4'($urandom);
      bus_if.id_rs2       = 4'($urandom);
      bus_if.id_rd        = 4'($urandom);
      bus_if.id_imm       = 16'($urandom);
      bus_if.id_alu_op    = 4'($urandom);
      bus_if.id_mem_read  = 1'($urandom);
      bus_if.id_mem_write = 1'($urandom);
      bus_if.id_reg_write = 1'($urandom);
      bus_if.id_branch    = 1'($urandom);
      step();
    end

    // Reset asserted in the middle of a stall and a redirect.
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    step();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h1111);
    step();
    chk("midstall_rst_pc", bus_if.pc, 16'h0000);
    chk("midstall_rst_valids", {bus_if.ifid_valid, bus_if.idex_valid}, 2'b00);
    chk("midstall_rst_cnts", {bus_if.stall_cnt, bus_if.flush_cnt}, 32'h0);

    // Stall counter saturation after 65536 stalls.
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 65536; i++) step(1'b0);
    check_all();
    chk("stall_sat", bus_if.stall_cnt, 16'hFFFF);
    step();
    chk("stall_sat_hold", bus_if.stall_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_front_regs.md
Name: pipe_front_regs

Overview:
- Front-end pipeline state of the 16-bit CPU: PC register, IF/ID register and ID/EX register.
- Consumes the stall/flush controls produced by the hazard unit (pc_write, ifid_write, idex_flush) and the EX-stage branch redirect.
- Produces the registered fields the hazard unit and the EX1 stage read: ifid_rs1/rs2, idex_rd, idex_mem_read, and the rest.
- Sits between instruction memory / decoder and the EX1 datapath.

Parameters:
- DATA_W, 16, instruction/PC/immediate width
- REG_AW, 4, register address width (16 GPRs, R0 hardwired zero)
- ALU_OP_W, 4, ALU opcode width
- RESET_PC, 16'h0000, PC value after reset
- PC_INC, 1, PC increment per fetch (word-addressed instruction memory)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- imem_instr  in  DATA_W  instruction fetched at pc
- pc_write  in  1  1 = advance PC, 0 = hold
- ifid_write  in  1  1 = load IF/ID, 0 = hold
- idex_flush  in  1  1 = load bubble into ID/EX
- ex_redirect  in  1  taken branch/jump resolved in EX1
- ex_target  in  DATA_W  redirect PC
- id_rs1, id_rs2, id_rd  in  REG_AW  decoded register fields of IF/ID instruction
- id_imm  in  DATA_W  decoded immediate
- id_alu_op  in  ALU_OP_W  decoded ALU op
- id_mem_read, id_mem_write, id_reg_write, id_branch  in  1  decoded controls
- pc  out  DATA_W  fetch address
- ifid_instr, ifid_pc  out  DATA_W  IF/ID contents
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_rs1, ifid_rs2  out  REG_AW  = id_rs1/id_rs2 when ifid_valid, else 0
- idex_rs1, idex_rs2, idex_rd  out  REG_AW  ID/EX register fields
- idex_imm, idex_pc  out  DATA_W
- idex_alu_op  out  ALU_OP_W
- idex_mem_read, idex_mem_write, idex_reg_write, idex_branch, idex_valid  out  1
- stall_cnt, flush_cnt  out  16  saturating perf counters

Behaviour:
- Reset (rst_n=0 at clk edge):
  - pc=RESET_PC.
  - All ifid_*/idex_* registers = 0, including valids, so every stage holds a NOP (instr 16'h0000).
  - Counters = 0.
  - Reset overrides every other input, including in mid-stall or mid-redirect.
- PC update, highest priority first:
  - ex_redirect: pc<=ex_target.
  - else pc_write: pc<=pc+PC_INC (mod 2^16; 16'hFFFF wraps to 16'h0000).
  - else hold.
- IF/ID update:
  - ex_redirect: bubble (instr=0, pc=0, valid=0). This overrides ifid_write=0.
  - else ifid_write: instr<=imem_instr, pc<=pc, valid<=1.
  - else hold all fields.
- ID/EX update:
  - ex_redirect or idex_flush: bubble (all control bits 0, rd/rs1/rs2=0, imm=0, alu_op=0, valid=0).
  - else load the decoded id_* fields, with idex_pc<=ifid_pc and idex_valid<=ifid_valid.
  - If ifid_valid=0, all control bits load 0 regardless of id_* inputs.
- Latency: an instruction fetched at cycle N is in IF/ID at N+1 and in ID/EX at N+2, absent stalls.
- Load-use stall:
  - Hazard unit drives pc_write=0, ifid_write=0, idex_flush=1 for one cycle.
  - PC and IF/ID hold; ID/EX receives exactly one bubble.
  - The following cycle the held instruction enters ID/EX.
- Simultaneous ex_redirect and stall: redirect wins. PC=target, IF/ID and ID/EX are both bubbled, and the stall is discarded.
- pc_write≠ifid_write is legal; each register obeys its own enable.
- stall_cnt increments when idex_flush=1 and ex_redirect=0.
- flush_cnt increments when ex_redirect=1.
- Both counters saturate at 16'hFFFF.

Decomposition:
- Shared cpu_pkg holds:
  - DATA_W, REG_AW, ALU_OP_W
  - NOP encoding 16'h0000, RESET_PC
  - Packed ID/EX control struct: {mem_read, mem_write, reg_write, branch, alu_op}
- One natural sub-module, sat_counter16 (enable, synchronous active-low reset), instantiated twice for the perf counters.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with imem_instr=16'h1234 -> pc=0, ifid_valid=0, idex_valid=0, all counters 0. Release -> pc=1 after 1 cycle, ifid_instr=16'h1234, ifid_pc=0.
- Straight-line: feed instructions A,B,C at pc 0,1,2 with no stalls -> A reaches ID/EX (idex_pc=0, idex_valid=1) on cycle 2. pc increments by 1 each cycle.
- Load-use: ID/EX holds a load with rd=3, and IF/ID holds an instruction with rs1=3. Drive pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle -> pc and ifid_instr unchanged, idex_valid=0 with idex_mem_read=0, stall_cnt=1. Next cycle the held instruction appears in ID/EX.
- Redirect: ex_redirect=1, ex_target=16'h0040 -> pc=16'h0040, ifid_valid=0, idex_valid=0, flush_cnt=1.
- Redirect coincident with stall (pc_write=0, ifid_write=0, idex_flush=1, ex_redirect=1) -> pc=16'h0040, both stages bubbled, stall_cnt unchanged.
- Edge cases:
  - PC wrap: pc=16'hFFFF, pc_write=1 -> pc=16'h0000.
  - Mid-stall reset: rst_n=0 -> all outputs at reset values.
  - Saturation: force 65536 flushes -> stall_cnt=16'hFFFF and stays there.
